// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the SDRAM host bridge: issue FSM encoding and
// request word layout {we, addr, wdata}.
package sdram_bridge_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } bridge_state_t;

   // Width of one queued request word: write flag, word address, write data.
   function automatic int req_w(input int haddr_w);
      return 1 + haddr_w + DATA_W;
   endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Small synchronous request FIFO with registered pointers and a full/empty
// flag pair. A pop and a push in the same cycle on a full FIFO are both
// honoured: the pop frees the slot the push then fills.
module sdram_req_fifo #(
   parameter int WIDTH      = 41,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

   // Storage array; data words need no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
      end
   end

   // Read/write pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/sdram_host_bridge.sv
// Host-side request/response front end for the SDRAM controller. Requests are
// queued in sdram_req_fifo and issued one at a time with the controller's
// level-held rd_enable/wr_enable + busy protocol; one in-order response is
// returned per request.
// Optional feature: define SDRAM_BRIDGE_WATCHDOG_EN to build a per-request
// watchdog that aborts a stuck request with rsp_err after TIMEOUT_CYCLES.
module sdram_host_bridge #(
   parameter int HADDR_WIDTH     = 24,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int TIMEOUT_CYCLES  = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [HADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]            req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [15:0]            rsp_rdata,
   output logic                   rsp_err,
   output logic [HADDR_WIDTH-1:0] ctl_haddr,
   output logic [15:0]            ctl_data_input,
   output logic                   ctl_rd_enable,
   output logic                   ctl_wr_enable,
   input  logic                   ctl_busy,
   input  logic [15:0]            ctl_data_output
);

   import sdram_bridge_pkg::*;

   localparam int REQ_W = req_w(HADDR_WIDTH);

   bridge_state_t          state;
   logic                   cur_we;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [REQ_W-1:0]       fifo_head;
   logic                   head_we;
   logic [HADDR_WIDTH-1:0] head_addr;
   logic [15:0]            head_wdata;
   logic                   wd_expired;

   assign req_ready  = ~fifo_full;
   assign fifo_pop   = (state == IDLE) && !fifo_empty;
   assign head_we    = fifo_head[REQ_W-1];
   assign head_addr  = fifo_head[DATA_W +: HADDR_WIDTH];
   assign head_wdata = fifo_head[DATA_W-1:0];

   sdram_req_fifo #(
      .WIDTH      (REQ_W),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_valid & req_ready),
      .push_data ({req_we, req_addr, req_wdata}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef SDRAM_BRIDGE_WATCHDOG_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            rsp_err_q;

   // Expiry fires on the cycle the count would reach TIMEOUT_CYCLES, so the
   // abort lands on the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT.
   assign wd_expired = (wd_cnt == WD_LAST);
   assign rsp_err    = rsp_err_q;

   // Watchdog counter: cleared as a request is popped, counts in ISSUE/WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (fifo_pop) begin
         wd_cnt <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   // Issue FSM with registered controller-side and response-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cur_we         <= 1'b0;
         ctl_haddr      <= '0;
         ctl_data_input <= '0;
         ctl_rd_enable  <= 1'b0;
         ctl_wr_enable  <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
`ifdef SDRAM_BRIDGE_WATCHDOG_EN
         rsp_err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_we         <= head_we;
                  ctl_haddr      <= head_addr;
                  ctl_data_input <= head_wdata;
                  ctl_rd_enable  <= ~head_we;
                  ctl_wr_enable  <= head_we;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               // The controller only samples the enable when idle, so it is
               // simply held through init/refresh until busy acknowledges it.
               if (ctl_busy) begin
                  ctl_rd_enable <= 1'b0;
                  ctl_wr_enable <= 1'b0;
                  state         <= WAIT;
               end else if (wd_expired) begin
                  ctl_rd_enable <= 1'b0;
                  ctl_wr_enable <= 1'b0;
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
`ifdef SDRAM_BRIDGE_WATCHDOG_EN
                  rsp_err_q     <= 1'b1;
`endif
                  state         <= RESP;
               end
            end
            WAIT: begin
               if (!ctl_busy) begin
                  rsp_rdata <= cur_we ? 16'h0000 : ctl_data_output;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wd_expired) begin
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
`ifdef SDRAM_BRIDGE_WATCHDOG_EN
                  rsp_err_q <= 1'b1;
`endif
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
`ifdef SDRAM_BRIDGE_WATCHDOG_EN
                  rsp_err_q <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Bench for sdram_host_bridge with a behavioural SDRAM controller model
// (init period, refresh, busy rising 2 cycles after an accepted enable).
// The watchdog sequence is compiled only with SDRAM_BRIDGE_WATCHDOG_EN.
module tb_sdram_host_bridge;

   localparam int INIT_CYC   = 30;
   localparam int REF_PERIOD = 200;
   localparam int REF_LEN    = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [23:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [23:0] ctl_haddr;
   logic [15:0] ctl_data_input;
   logic        ctl_rd_enable;
   logic        ctl_wr_enable;
   logic        ctl_busy;
   logic [15:0] ctl_data_output;

   // Expected response attached to the request currently being driven.
   logic [15:0] req_exp_rdata = '0;
   logic        req_exp_err = 1'b0;
   logic        force_ref = 1'b0;
   logic        stuck = 1'b0;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   en_total = 0;
   int   viol = 0;
   int   rsp_seen = 0;

   always #5 clk = ~clk;

   sdram_host_bridge #(
      .HADDR_WIDTH     (24),
      .FIFO_DEPTH_LOG2 (2),
      .TIMEOUT_CYCLES  (50)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .ctl_haddr       (ctl_haddr),
      .ctl_data_input  (ctl_data_input),
      .ctl_rd_enable   (ctl_rd_enable),
      .ctl_wr_enable   (ctl_wr_enable),
      .ctl_busy        (ctl_busy),
      .ctl_data_output (ctl_data_output)
   );

   // ---------------- controller model ----------------
   typedef enum logic [1:0] {M_INIT, M_IDLE, M_REF, M_OP} mst_t;
   mst_t        m_st;
   int          m_cnt;
   int          ref_cnt;
   int          n_bact = 0;
   int          n_ref = 0;
   logic        op_we;
   logic [7:0]  op_addr;
   logic [15:0] op_d;
   logic [15:0] mem [256] = '{default: 16'h0000};

   // Controller model: samples enables only in idle, busy 2 cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st            <= M_INIT;
         m_cnt           <= 0;
         ref_cnt         <= 0;
         ctl_busy        <= 1'b0;
         ctl_data_output <= 16'h0000;
         op_we           <= 1'b0;
         op_addr         <= 8'h00;
         op_d            <= 16'h0000;
      end else begin
         if (m_st != M_REF) ref_cnt <= ref_cnt + 1;
         case (m_st)
            M_INIT: begin
               m_cnt <= m_cnt + 1;
               if (m_cnt == INIT_CYC - 1) begin
                  m_st  <= M_IDLE;
                  m_cnt <= 0;
               end
            end
            M_IDLE: begin
               if (ref_cnt >= REF_PERIOD || force_ref) begin
                  m_st    <= M_REF;
                  m_cnt   <= 0;
                  ref_cnt <= 0;
                  n_ref   <= n_ref + 1;
               end else if ((ctl_rd_enable || ctl_wr_enable) && !stuck) begin
                  m_st    <= M_OP;
                  m_cnt   <= 0;
                  op_we   <= ctl_wr_enable;
                  op_addr <= ctl_haddr[7:0];
                  op_d    <= ctl_data_input;
                  n_bact  <= n_bact + 1;
               end
            end
            M_REF: begin
               m_cnt <= m_cnt + 1;
               if (m_cnt == REF_LEN - 1) begin
                  m_st  <= M_IDLE;
                  m_cnt <= 0;
               end
            end
            default: begin
               m_cnt <= m_cnt + 1;
               if (m_cnt == 1) ctl_busy <= 1'b1;
               if (m_cnt == (op_we ? 6 : 9)) begin
                  ctl_busy <= 1'b0;
                  if (op_we) mem[op_addr] <= op_d;
                  else       ctl_data_output <= mem[op_addr];
                  m_st  <= M_IDLE;
                  m_cnt <= 0;
               end
            end
         endcase
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one request; returns one cycle after it is accepted, valid left high.
   task automatic send(input logic we, input logic [23:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee);
      int t = 0;
      req_valid     = 1'b1;
      req_we        = we;
      req_addr      = a;
      req_wdata     = d;
      req_exp_rdata = er;
      req_exp_err   = ee;
      while (!req_ready && t < 500) begin
         step();
         t++;
      end
      check("send_accepted", {31'd0, req_ready}, 32'd1);
      step();
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         step();
         t++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      step();
   endtask

   // Scoreboard and protocol monitor, sampling on the falling edge.
   task automatic monitor();
      logic busy_last = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (ctl_rd_enable && ctl_wr_enable) viol++;
         if ((ctl_rd_enable || ctl_wr_enable) && busy_last) viol++;
         if (ctl_rd_enable || ctl_wr_enable) en_total++;
         busy_last = ctl_busy;
         if (!rst_n) begin
            exp_q.delete();
            busy_last = 1'b0;
         end else begin
            if (req_valid && req_ready) begin
               e.rdata = req_exp_rdata;
               e.err   = req_exp_err;
               exp_q.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
               rsp_seen++;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: got rdata 0x%0h with no request pending", rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                  check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               end
            end
         end
      end
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl[6];
   int   b0, e0, r0, t;
   logic ok;

   initial begin
      tbl[0] = '{1'b1, 24'h012345, 16'hBEEF, 16'h0000};
      tbl[1] = '{1'b0, 24'h012345, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b1, 24'h0000A0, 16'h0001, 16'h0000};
      tbl[3] = '{1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0000};
      tbl[4] = '{1'b0, 24'hFFFFFF, 16'h0000, 16'hFFFF};
      tbl[5] = '{1'b0, 24'h000077, 16'h0000, 16'h0000};

      fork
         monitor();
      join_none

      // Reset values.
      step(3);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_enables", {30'd0, ctl_rd_enable, ctl_wr_enable}, 32'd0);
      check("rst_haddr", {8'd0, ctl_haddr}, 32'd0);
      check("rst_data_input", {16'd0, ctl_data_input}, 32'd0);

      // Request during controller init: enable held, exactly one BACT.
      rst_n = 1'b1;
      b0 = n_bact;
      e0 = en_total;
      send(1'b1, 24'h000011, 16'h1111, 16'h0000, 1'b0);
      req_valid = 1'b0;
      drain("init_req");
      check("init_one_bact", n_bact - b0, 1);
      check("init_enable_held", {31'd0, (en_total - e0) >= 20}, 32'd1);

      // Table of single requests.
      for (int i = 0; i < 6; i++) begin
         b0 = n_bact;
         send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, 1'b0);
         req_valid = 1'b0;
         drain("tbl");
         check("tbl_one_bact", n_bact - b0, 1);
      end

      // Burst with response back-pressure: fill FIFO, hold response 20 cycles.
      rsp_ready = 1'b0;
      for (int i = 1; i <= 4; i++)
         send(1'b1, 24'(i * 24'h000101), 16'(16'hA000 + i), 16'h0000, 1'b0);
      check("ready_before_full", {31'd0, req_ready}, 32'd1);
      send(1'b0, 24'h000101, 16'h0000, 16'hA001, 1'b0);
      check("ready_when_full", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      t = 0;
      while (!rsp_valid && t < 500) begin
         step();
         t++;
      end
      check("burst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      b0 = n_bact;
      e0 = en_total;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!rsp_valid || rsp_rdata !== 16'h0000) ok = 1'b0;
      end
      check("hold_stable", {31'd0, ok}, 32'd1);
      check("hold_no_enable", en_total - e0, 0);
      check("hold_no_bact", n_bact - b0, 0);
      rsp_ready = 1'b1;
      for (int i = 2; i <= 4; i++)
         send(1'b0, 24'(i * 24'h000101), 16'h0000, 16'(16'hA000 + i), 1'b0);
      req_valid = 1'b0;
      drain("burst");

      // Refresh due just as a request arrives.
      r0 = n_ref;
      force_ref = 1'b1;
      send(1'b0, 24'h012345, 16'h0000, 16'hBEEF, 1'b0);
      force_ref = 1'b0;
      req_valid = 1'b0;
      e0 = en_total;
      drain("refresh");
      check("refresh_taken", n_ref - r0, 1);

`ifdef SDRAM_BRIDGE_WATCHDOG_EN
      // Controller never acknowledges: watchdog aborts after 50 cycles.
      stuck = 1'b1;
      e0 = en_total;
      send(1'b0, 24'h000055, 16'h0000, 16'h0000, 1'b1);
      req_valid = 1'b0;
      drain("watchdog");
      check("wd_enable_cycles", en_total - e0, 50);
      stuck = 1'b0;
      send(1'b0, 24'h012345, 16'h0000, 16'hBEEF, 1'b0);
      req_valid = 1'b0;
      drain("after_wd");
`endif

      // Reset mid-request: request dropped, no response, clean restart.
      send(1'b0, 24'h000404, 16'h0000, 16'hA004, 1'b0);
      req_valid = 1'b0;
      step(5);
      rst_n = 1'b0;
      r0 = rsp_seen;
      step(2);
      check("midrst_ready", {31'd0, req_ready}, 32'd1);
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_enables", {30'd0, ctl_rd_enable, ctl_wr_enable}, 32'd0);
      rst_n = 1'b1;
      step(40);
      check("midrst_no_rsp", rsp_seen - r0, 0);
      send(1'b0, 24'h000404, 16'h0000, 16'hA004, 1'b0);
      req_valid = 1'b0;
      drain("after_rst");

      check("enable_protocol", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
